// File: rtl/keypad_pkg.sv
// Shared definitions for the 12-key keypad scanner: code width, special keys and FSM states.
package keypad_pkg;

  localparam int unsigned CODE_W = 4;

  localparam logic [CODE_W-1:0] KEY_STAR  = 4'd10;
  localparam logic [CODE_W-1:0] KEY_SHARP = 4'd11;
  localparam logic [CODE_W-1:0] LAST_CODE = 4'd11;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StHeld,
    StRelease
  } kp_state_e;

  // Next select code; wraps after '#' so codes 12-15 are never produced.
  function automatic logic [CODE_W-1:0] next_code(input logic [CODE_W-1:0] code);
    return (code == LAST_CODE) ? '0 : code + 4'd1;
  endfunction

endpackage

// File: rtl/keypad_debounce_cnt.sv
// Saturating consecutive-sample counter shared by press and release debouncing.
module keypad_debounce_cnt #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_last
);

  localparam int unsigned W = $clog2(LIMIT) + 1;

  logic [W-1:0] r_cnt;

  // o_last: the next consecutive sample would bring the count to LIMIT.
  assign o_last = (r_cnt == W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= W'(1);
    end else if (i_inc && (r_cnt != W'(LIMIT))) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// Scans a 12-way key mux, debounces press and release of one key at a time,
// and reports accepted keys with a one-cycle valid pulse.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DWELL      = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_in,
  output logic [CODE_W-1:0] sel_out,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held
);

  localparam int unsigned DW = $clog2(SCAN_DWELL) + 1;

  kp_state_e         r_state;
  logic [DW-1:0]     r_dwell;
  logic [CODE_W-1:0] r_sel;
  logic [CODE_W-1:0] r_code;
  logic              r_valid;
  logic              r_held;

  logic w_sample;
  logic w_cnt_load;
  logic w_cnt_inc;
  logic w_cnt_clr;
  logic w_cnt_last;

  // key_in is only trusted in the last dwell cycle, once the mux has settled.
  assign w_sample = (r_dwell == DW'(SCAN_DWELL - 1));

  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_inc  = 1'b0;
    w_cnt_clr  = 1'b0;
    unique case (r_state)
      StScan:     w_cnt_load = w_sample && key_in;
      StDebounce: if (key_in && !w_cnt_last) w_cnt_inc = 1'b1; else w_cnt_clr = 1'b1;
      StHeld:     if (!key_in) w_cnt_load = 1'b1; else w_cnt_clr = 1'b1;
      StRelease:  if (!key_in && !w_cnt_last) w_cnt_inc = 1'b1; else w_cnt_clr = 1'b1;
      default:    w_cnt_clr = 1'b1;
    endcase
  end

  keypad_debounce_cnt #(
    .LIMIT (DEBOUNCE_CYCLES)
  ) u_debounce_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_cnt_load),
    .i_inc  (w_cnt_inc),
    .i_clr  (w_cnt_clr),
    .o_last (w_cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StScan;
      r_dwell <= '0;
      r_sel   <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      unique case (r_state)
        StScan: begin
          if (w_sample) begin
            r_dwell <= '0;
            if (key_in) r_state <= StDebounce;
            else        r_sel   <= next_code(r_sel);
          end else begin
            r_dwell <= r_dwell + DW'(1);
          end
        end
        StDebounce: begin
          if (!key_in) begin
            r_state <= StScan;
            r_sel   <= next_code(r_sel);
            r_dwell <= '0;
          end else if (w_cnt_last) begin
            r_state <= StHeld;
            r_code  <= r_sel;
            r_valid <= 1'b1;
            r_held  <= 1'b1;
          end
        end
        StHeld: begin
          if (!key_in) r_state <= StRelease;
        end
        StRelease: begin
          if (key_in) begin
            r_state <= StHeld;
          end else if (w_cnt_last) begin
            r_state <= StScan;
            r_held  <= 1'b0;
            r_sel   <= next_code(r_sel);
            r_dwell <= '0;
          end
        end
        default: r_state <= StScan;
      endcase
    end
  end

  assign sel_out   = r_sel;
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = r_held;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: models the key mux as key_in = pressed[sel_out].
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic              clk;
  logic              rst;
  logic              key_in;
  logic [CODE_W-1:0] sel_out;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_held;

  logic [15:0] pressed;
  int          cyc;
  int          n_valid;
  int          n_bad_sel;
  int          n_checks;
  int          n_pass;
  int          v0;

  keypad_scanner #(
    .SCAN_DWELL      (2),
    .DEBOUNCE_CYCLES (4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .sel_out   (sel_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  assign key_in = pressed[sel_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  // Advance one clock; all observation happens on the falling edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (key_valid) n_valid++;
    if (sel_out > 4'd11) n_bad_sel++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_valid = 0; n_bad_sel = 0; cyc = 0;
    pressed = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_sel", sel_out, 0);
    check("rst_code", key_code, 0);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);

    // Idle scan: two cycles per code, wrap 11 -> 0.
    do_reset();
    for (int i = 0; i < 30; i++) begin
      check("idle_seq", sel_out, (i / 2) % 12);
      tick();
    end

    // Key 3 held 60 cycles.
    do_reset();
    v0 = n_valid;
    pressed[3] = 1'b1;
    run_to(10);
    check("k3_pre_valid", key_valid, 0);
    run_to(11);
    check("k3_valid", key_valid, 1);
    check("k3_code", key_code, 3);
    check("k3_held", key_held, 1);
    run_to(68);
    check("k3_one_valid", n_valid - v0, 1);
    check("k3_sel_frozen", sel_out, 3);
    pressed[3] = 1'b0;
    run_to(71);
    check("k3_held_rel", key_held, 1);
    run_to(72);
    check("k3_released", key_held, 0);
    check("k3_sel_next", sel_out, 4);
    run_to(74);
    check("k3_scan_on", sel_out, 5);
    check("k3_code_kept", key_code, 3);

    // Key 7 too short.
    do_reset();
    v0 = n_valid;
    pressed[7] = 1'b1;
    run_to(18);
    check("k7_sel_hold", sel_out, 7);
    pressed[7] = 1'b0;
    run_to(19);
    check("k7_sel_adv", sel_out, 8);
    run_to(30);
    check("k7_no_valid", n_valid - v0, 0);
    check("k7_no_held", key_held, 0);

    // '#' with a 2-cycle glitch while held.
    do_reset();
    v0 = n_valid;
    pressed[KEY_SHARP] = 1'b1;
    run_to(27);
    check("sh_valid", key_valid, 1);
    check("sh_code", key_code, KEY_SHARP);
    run_to(32);
    pressed[KEY_SHARP] = 1'b0;
    run_to(34);
    check("sh_glitch_held", key_held, 1);
    pressed[KEY_SHARP] = 1'b1;
    run_to(40);
    check("sh_after_glitch", key_held, 1);
    check("sh_one_valid", n_valid - v0, 1);
    pressed[KEY_SHARP] = 1'b0;
    run_to(43);
    check("sh_held_rel", key_held, 1);
    run_to(44);
    check("sh_released", key_held, 0);
    check("sh_wrap", sel_out, 0);

    // Reset on the edge that would deliver key 5's valid.
    do_reset();
    v0 = n_valid;
    pressed[5] = 1'b1;
    run_to(14);
    rst = 1'b1;
    tick();
    check("rv_valid_supp", key_valid, 0);
    check("rv_code", key_code, 0);
    check("rv_count", n_valid - v0, 0);

    // Reset while holding key 5.
    do_reset();
    run_to(15);
    check("k5_valid", key_valid, 1);
    check("k5_code", key_code, 5);
    run_to(20);
    rst = 1'b1;
    tick();
    check("k5_rst_sel", sel_out, 0);
    check("k5_rst_held", key_held, 0);
    check("k5_rst_valid", key_valid, 0);
    check("k5_rst_code", key_code, 0);
    pressed = '0;
    do_reset();
    run_to(1);
    check("k5_restart0", sel_out, 0);
    run_to(2);
    check("k5_restart1", sel_out, 1);

    // Keys 2 and 9 together.
    do_reset();
    v0 = n_valid;
    pressed[2] = 1'b1;
    pressed[9] = 1'b1;
    run_to(9);
    check("k29_valid2", key_valid, 1);
    check("k29_code2", key_code, 2);
    run_to(20);
    check("k29_only2", n_valid - v0, 1);
    check("k29_sel2", sel_out, 2);
    pressed[2] = 1'b0;
    run_to(24);
    check("k29_sel3", sel_out, 3);
    run_to(40);
    check("k29_pre9", key_valid, 0);
    run_to(41);
    check("k29_valid9", key_valid, 1);
    check("k29_code9", key_code, 9);
    pressed = '0;

    check("never_12_15", n_bad_sel, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
